// File: rtl/stage_seq_pkg.sv
// Shared definitions for the multi-stage burn sequencer: state encoding,
// stage index width and default parameter values.
package stage_seq_pkg;

  localparam int IDX_W           = 4;
  localparam int DEF_W           = 64;
  localparam int DEF_TICKS_PER_S = 1000;

  // Binary state encoding
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_ARM   = 3'd2;
  localparam logic [ST_W-1:0] ST_BURN  = 3'd3;
  localparam logic [ST_W-1:0] ST_SEP   = 3'd4;
  localparam logic [ST_W-1:0] ST_COAST = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd6;
  localparam logic [ST_W-1:0] ST_ABORT = 3'd7;

  // Width of a counter that must hold values 0..n-1 (at least one bit)
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_sequencer_burn_watchdog.sv
// Burn-time watchdog: counts BURN cycles since the last ARM and flags when
// the count reaches burntime*TICKS_PER_S. Only instantiated by the sequencer
// when STAGE_SEQ_WDOG_EN is defined.
module burn_watchdog
  import stage_seq_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int TICKS_PER_S = DEF_TICKS_PER_S
) (
  input  logic         clk_i,
  input  logic         resetb_i,
  input  logic         clear_i,
  input  logic         count_i,
  input  logic [W-1:0] burntime_i,
  output logic         trip_o
);

  // Wide enough for burntime*TICKS_PER_S without overflow
  localparam int CW = W + $clog2(TICKS_PER_S + 1);

  logic [CW-1:0] cnt_q, cnt_d, limit;

  assign limit = CW'(burntime_i) * CW'(TICKS_PER_S);

  // Trip on the BURN cycle that completes the allowed number of ticks
  assign trip_o = count_i && ((cnt_q + CW'(1)) >= limit);

  // Next count: clear while armed, advance while burning, hold otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-stage burn sequencer: loads per-stage parameters, arms and runs each
// stage's velocity engine, separates, coasts and advances until the last
// stage is spent, with a sticky abort path.
// Optional burn watchdog enabled by defining STAGE_SEQ_WDOG_EN.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int W            = DEF_W,
  parameter int COAST_CYCLES = 2,
  parameter int TICKS_PER_S  = DEF_TICKS_PER_S
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  launch,
  input  logic                  ignition_end,
  input  logic                  abort,
  input  logic [NUM_STAGES*W-1:0] isp_tbl,
  input  logic [NUM_STAGES*W-1:0] mass0_tbl,
  input  logic [NUM_STAGES*W-1:0] prop_tbl,
  input  logic [NUM_STAGES*W-1:0] burn_tbl,
  output logic [IDX_W-1:0]      stage_idx,
  output logic [W-1:0]          isp,
  output logic [W-1:0]          initial_weight,
  output logic [W-1:0]          propellant_weight,
  output logic [W-1:0]          burntime,
  output logic                  engine_resetb,
  output logic                  burning,
  output logic                  sep_pulse,
  output logic                  mission_done,
  output logic                  aborted,
  output logic                  wdog_trip
);

  if (NUM_STAGES < 2 || NUM_STAGES > 15 || TICKS_PER_S < 1) begin : g_bad_param
    $error("stage_sequencer: NUM_STAGES must be 2..15 and TICKS_PER_S >= 1");
  end

  localparam int              CCW        = ctr_w(COAST_CYCLES);
  localparam logic [CCW-1:0]  COAST_LAST = CCW'((COAST_CYCLES > 0) ? COAST_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] stage_q, stage_d;
  logic [CCW-1:0]   coast_q, coast_d;
  logic [W-1:0]     isp_q, mass0_q, prop_q, burn_q;
  logic             load_params;
  logic             wdog_hit;

  // Sequencing decisions; abort from any active state overrides everything
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    coast_d     = coast_q;
    load_params = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_LOAD;
          stage_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else begin
          state_d     = ST_ARM;
          load_params = 1'b1;
        end
      end
      ST_ARM: begin
        state_d = abort ? ST_ABORT : ST_BURN;
      end
      ST_BURN: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (ignition_end || wdog_hit) begin
          state_d = ST_SEP;
        end
      end
      ST_SEP: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (stage_q == LAST_STAGE) begin
          state_d = ST_DONE;
        end else if (COAST_CYCLES == 0) begin
          state_d = ST_LOAD;
          stage_d = stage_q + IDX_W'(1);
        end else begin
          state_d = ST_COAST;
          coast_d = '0;
        end
      end
      ST_COAST: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (coast_q == COAST_LAST) begin
          state_d = ST_LOAD;
          stage_d = stage_q + IDX_W'(1);
        end else begin
          coast_d = coast_q + CCW'(1);
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ABORT: state_d = ST_ABORT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state, stage index and coast counter
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      coast_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      coast_q <= coast_d;
    end
  end

  // Latch the current stage's parameters on the way from LOAD to ARM
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      isp_q   <= '0;
      mass0_q <= '0;
      prop_q  <= '0;
      burn_q  <= W'(1);
    end else if (load_params) begin
      isp_q   <= isp_tbl[int'(stage_q)*W +: W];
      mass0_q <= mass0_tbl[int'(stage_q)*W +: W];
      prop_q  <= prop_tbl[int'(stage_q)*W +: W];
      burn_q  <= burn_tbl[int'(stage_q)*W +: W];
    end
  end

`ifdef STAGE_SEQ_WDOG_EN
  logic wdog_q;

  burn_watchdog #(
    .W           (W),
    .TICKS_PER_S (TICKS_PER_S)
  ) u_burn_watchdog (
    .clk_i      (clk),
    .resetb_i   (resetb),
    .clear_i    (state_q == ST_ARM),
    .count_i    (state_q == ST_BURN),
    .burntime_i (burn_q),
    .trip_o     (wdog_hit)
  );

  // Sticky trip flag: set only when the watchdog, not the engine, ends the burn
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wdog_q <= 1'b0;
    end else if (state_q == ST_BURN && !abort && !ignition_end && wdog_hit) begin
      wdog_q <= 1'b1;
    end
  end

  assign wdog_trip = wdog_q;
`else
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  assign stage_idx         = stage_q;
  assign isp               = isp_q;
  assign initial_weight    = mass0_q;
  assign propellant_weight = prop_q;
  assign burntime          = burn_q;

  // Engine held in reset while our own reset is low, while arming, and after abort
  assign engine_resetb = resetb & (state_q != ST_ARM) & (state_q != ST_ABORT);
  assign burning       = (state_q == ST_BURN);
  assign sep_pulse     = (state_q == ST_SEP);
  assign mission_done  = (state_q == ST_DONE);
  assign aborted       = (state_q == ST_ABORT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: three instances (coast 2, coast 0, fast ticks),
// a timestamp-based expectation model compared every cycle, plus directed
// literal checks.
module tb_stage_sequencer;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int VW = 4 + 4*W + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb = 1'b0;
  logic launch [3] = '{1'b0, 1'b0, 1'b0};
  logic ign    [3] = '{1'b0, 1'b0, 1'b0};
  logic abt    [3] = '{1'b0, 1'b0, 1'b0};

  logic [W-1:0] isp_t  [NS] = '{32'd263, 32'd421, 32'd421, 32'd421};
  logic [W-1:0] m0_t   [NS] = '{32'd9000, 32'd4000, 32'd2500, 32'd1200};
  logic [W-1:0] prop_t [NS] = '{32'd7000, 32'd3000, 32'd1800, 32'd800};
  logic [W-1:0] burn_t [NS] = '{32'd2, 32'd3, 32'd4, 32'd5};
  logic [NS*W-1:0] isp_p, m0_p, prop_p, burn_p;

  logic [3:0]   o_idx  [3];
  logic [W-1:0] o_isp  [3];
  logic [W-1:0] o_m0   [3];
  logic [W-1:0] o_prop [3];
  logic [W-1:0] o_burn [3];
  logic o_eng [3], o_brn [3], o_sep [3], o_done [3], o_abt [3], o_wd [3];

  stage_sequencer #(.NUM_STAGES(NS), .W(W), .COAST_CYCLES(2)) u0 (
    .clk(clk), .resetb(resetb), .launch(launch[0]), .ignition_end(ign[0]), .abort(abt[0]),
    .isp_tbl(isp_p), .mass0_tbl(m0_p), .prop_tbl(prop_p), .burn_tbl(burn_p),
    .stage_idx(o_idx[0]), .isp(o_isp[0]), .initial_weight(o_m0[0]),
    .propellant_weight(o_prop[0]), .burntime(o_burn[0]), .engine_resetb(o_eng[0]),
    .burning(o_brn[0]), .sep_pulse(o_sep[0]), .mission_done(o_done[0]),
    .aborted(o_abt[0]), .wdog_trip(o_wd[0]));

  stage_sequencer #(.NUM_STAGES(NS), .W(W), .COAST_CYCLES(0)) u1 (
    .clk(clk), .resetb(resetb), .launch(launch[1]), .ignition_end(ign[1]), .abort(abt[1]),
    .isp_tbl(isp_p), .mass0_tbl(m0_p), .prop_tbl(prop_p), .burn_tbl(burn_p),
    .stage_idx(o_idx[1]), .isp(o_isp[1]), .initial_weight(o_m0[1]),
    .propellant_weight(o_prop[1]), .burntime(o_burn[1]), .engine_resetb(o_eng[1]),
    .burning(o_brn[1]), .sep_pulse(o_sep[1]), .mission_done(o_done[1]),
    .aborted(o_abt[1]), .wdog_trip(o_wd[1]));

  stage_sequencer #(.NUM_STAGES(NS), .W(W), .COAST_CYCLES(1), .TICKS_PER_S(5)) u2 (
    .clk(clk), .resetb(resetb), .launch(launch[2]), .ignition_end(ign[2]), .abort(abt[2]),
    .isp_tbl(isp_p), .mass0_tbl(m0_p), .prop_tbl(prop_p), .burn_tbl(burn_p),
    .stage_idx(o_idx[2]), .isp(o_isp[2]), .initial_weight(o_m0[2]),
    .propellant_weight(o_prop[2]), .burntime(o_burn[2]), .engine_resetb(o_eng[2]),
    .burning(o_brn[2]), .sep_pulse(o_sep[2]), .mission_done(o_done[2]),
    .aborted(o_abt[2]), .wdog_trip(o_wd[2]));

  // ---------------- expectation model (event timestamps) ----------------
  typedef struct {
    bit run;          // a mission is in progress (LOAD..COAST)
    int stg;          // stage index shown on stage_idx
    int pend;         // stage that the next LOAD will select
    int arm_t;        // cycle in which the engine is (or will be) armed
    int sep_t;        // cycle of the most recent separation pulse
    int done_from;    // first cycle of mission_done, -1 if none
    int abort_from;   // first cycle of aborted, -1 if none
    bit wd;
    logic [W-1:0] isp, m0, prop, burn;
  } mdl_t;

  mdl_t m [3];
  int coast_of [3] = '{2, 0, 1};
`ifdef STAGE_SEQ_WDOG_EN
  longint ticks_of [3] = '{1000, 1000, 5};
`endif
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;
  int sepcnt0 = 0;

  function automatic mdl_t mreset();
    mdl_t r;
    r.run = 0; r.stg = 0; r.pend = 0; r.arm_t = -10; r.sep_t = -1;
    r.done_from = -1; r.abort_from = -1; r.wd = 0;
    r.isp = '0; r.m0 = '0; r.prop = '0; r.burn = 32'd1;
    return r;
  endfunction

  // Advance one clock: c is the cycle just ending, inputs are those sampled at its end
  function automatic mdl_t mstep(mdl_t s, int i, bit l, bit ig, bit ab, int c);
    int n;
    bit trip;
    n = c + 1;
    trip = 0;
    if (s.abort_from < 0 && (s.run || c == s.sep_t) && ab) begin
      s.abort_from = n;
      s.run = 0;
      s.done_from = -1;
    end else if (!s.run && s.done_from < 0 && s.abort_from < 0) begin
      if (l) begin
        s.run = 1; s.pend = 0; s.arm_t = n + 1;
      end
    end else if (s.run && c > s.arm_t) begin
`ifdef STAGE_SEQ_WDOG_EN
      trip = (longint'(c - s.arm_t) >= longint'(s.burn) * ticks_of[i]);
`endif
      if (ig || trip) begin
        if (!ig) s.wd = 1;
        s.sep_t = n;
        if (s.stg == NS - 1) begin
          s.run = 0; s.done_from = n + 1;
        end else begin
          s.pend = s.stg + 1;
          s.arm_t = n + 2 + coast_of[i];
        end
      end
    end
    if (s.run && n == s.arm_t - 1) s.stg = s.pend;
    if (s.run && n == s.arm_t) begin
      s.isp = isp_t[s.stg]; s.m0 = m0_t[s.stg]; s.prop = prop_t[s.stg]; s.burn = burn_t[s.stg];
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] mexp(mdl_t s, int n, bit rb);
    bit eng;
    eng = rb && !((s.run && n == s.arm_t) || s.abort_from >= 0);
    return {4'(s.stg), s.isp, s.m0, s.prop, s.burn, eng, (s.run && n > s.arm_t),
            (n == s.sep_t), (s.done_from >= 0 && n >= s.done_from), (s.abort_from >= 0), s.wd};
  endfunction

  always @(posedge clk or negedge resetb) begin
    for (int i = 0; i < 3; i++) begin
      if (!resetb) m[i] <= mreset();
      else         m[i] <= mstep(m[i], i, launch[i], ign[i], abt[i], cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("u%0d cyc%0d", i, cyc),
              {o_idx[i], o_isp[i], o_m0[i], o_prop[i], o_burn[i], o_eng[i], o_brn[i],
               o_sep[i], o_done[i], o_abt[i], o_wd[i]},
              mexp(m[i], cyc, resetb));
        end
        if (o_sep[0] === 1'b1) sepcnt0++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_arm(input int i, input string nm, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_eng[i] === 1'b0 && o_abt[i] !== 1'b1) begin
        ok = 1;
        break;
      end
      step(1);
      waited++;
    end
    chk({nm, " arm reached"}, VW'(ok), VW'(1));
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    step(2);
    resetb = 1'b1;
    step(1);
  endtask

  initial begin
    int w, lat, nb;
    bit sawsep;
    for (int k = 0; k < NS; k++) begin
      isp_p[k*W +: W]  = isp_t[k];
      m0_p[k*W +: W]   = m0_t[k];
      prop_p[k*W +: W] = prop_t[k];
      burn_p[k*W +: W] = burn_t[k];
    end
    step(3);
    chk_en = 1;
    step(1);
    chk("reset eng", VW'(o_eng[0]), VW'(0));
    chk("reset burntime", VW'(o_burn[0]), VW'(1));
    chk("reset isp", VW'(o_isp[0]), VW'(0));
    resetb = 1'b1;
    abt[0] = 1'b1;
    step(2);
    abt[0] = 1'b0;
    chk("idle ignores abort", VW'(o_abt[0]), VW'(0));
    chk("idle eng high", VW'(o_eng[0]), VW'(1));

    // Nominal four-stage mission, ignition_end 20 cycles after each ARM
    sepcnt0 = 0;
    launch[0] = 1'b1; step(1); launch[0] = 1'b0;
    chk("s0 load idx", VW'(o_idx[0]), VW'(0));
    step(1);
    chk("s0 isp", VW'(o_isp[0]), VW'(263));
    lat = 0;
    for (int s = 0; s < NS; s++) begin
      wait_arm(0, $sformatf("nominal s%0d", s), w);
      if (s > 0) chk($sformatf("ign to arm s%0d", s), VW'(lat + w), VW'(5));
      chk($sformatf("idx s%0d", s), VW'(o_idx[0]), VW'(s));
      if (s == 1) chk("s1 isp", VW'(o_isp[0]), VW'(421));
      if (s == 2) begin
        launch[0] = 1'b1; step(1); launch[0] = 1'b0; step(19);
      end else begin
        step(20);
      end
      ign[0] = 1'b1; step(1); ign[0] = 1'b0;
      chk($sformatf("sep s%0d", s), VW'(o_sep[0]), VW'(1));
      lat = 1;
      if (s == 1) begin
        ign[0] = 1'b1; step(1); ign[0] = 1'b0;
        lat = 2;
      end
    end
    step(1);
    chk("mission_done", VW'(o_done[0]), VW'(1));
    chk("final idx", VW'(o_idx[0]), VW'(3));
    chk("sep count", VW'(sepcnt0), VW'(4));
    abt[0] = 1'b1; step(2); abt[0] = 1'b0;
    chk("done ignores abort", VW'(o_abt[0]), VW'(0));

    // Abort together with ignition_end in stage 1 burn
    do_reset();
    sepcnt0 = 0;
    launch[0] = 1'b1; step(1); launch[0] = 1'b0;
    wait_arm(0, "abort s0", w);
    step(5);
    ign[0] = 1'b1; step(1); ign[0] = 1'b0;
    wait_arm(0, "abort s1", w);
    step(4);
    ign[0] = 1'b1; abt[0] = 1'b1; step(1); ign[0] = 1'b0; abt[0] = 1'b0;
    chk("aborted", VW'(o_abt[0]), VW'(1));
    chk("abort eng low", VW'(o_eng[0]), VW'(0));
    chk("abort no sep", VW'(o_sep[0]), VW'(0));
    step(3);
    chk("abort sticky", VW'(o_abt[0]), VW'(1));
    chk("abort burning", VW'(o_brn[0]), VW'(0));
    chk("abort sep count", VW'(sepcnt0), VW'(1));

    // Reset in the middle of stage 2 burn, then relaunch
    do_reset();
    launch[0] = 1'b1; step(1); launch[0] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      wait_arm(0, $sformatf("rst s%0d", s), w);
      step(3);
      ign[0] = 1'b1; step(1); ign[0] = 1'b0;
    end
    wait_arm(0, "rst s2", w);
    step(4);
    chk("s2 burning", VW'(o_brn[0]), VW'(1));
    resetb = 1'b0;
    #1;
    chk("midburn rst idx", VW'(o_idx[0]), VW'(0));
    chk("midburn rst burntime", VW'(o_burn[0]), VW'(1));
    chk("midburn rst m0", VW'(o_m0[0]), VW'(0));
    chk("midburn rst flags", VW'({o_eng[0], o_brn[0], o_abt[0], o_sep[0]}), VW'(0));
    step(2);
    resetb = 1'b1;
    step(1);
    chk("after rst eng", VW'(o_eng[0]), VW'(1));
    launch[0] = 1'b1; step(1); launch[0] = 1'b0;
    chk("relaunch idx", VW'(o_idx[0]), VW'(0));
    step(1);
    chk("relaunch isp", VW'(o_isp[0]), VW'(263));

    // Zero coast: ignition_end to next arm in three cycles
    launch[1] = 1'b1; step(1); launch[1] = 1'b0;
    wait_arm(1, "nocoast s0", w);
    step(3);
    ign[1] = 1'b1; step(1); ign[1] = 1'b0;
    wait_arm(1, "nocoast s1", w);
    chk("nocoast latency", VW'(1 + w), VW'(3));
    chk("nocoast idx", VW'(o_idx[1]), VW'(1));

    // No ignition_end on the fast-tick instance
    launch[2] = 1'b1; step(1); launch[2] = 1'b0;
    wait_arm(2, "wdog s0", w);
    nb = 0;
    sawsep = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (o_sep[2] === 1'b1) begin
        sawsep = 1;
        break;
      end
      if (o_brn[2] === 1'b1) nb++;
    end
`ifdef STAGE_SEQ_WDOG_EN
    chk("wdog sep", VW'(sawsep), VW'(1));
    chk("wdog burn cycles", VW'(nb), VW'(10));
    chk("wdog trip", VW'(o_wd[2]), VW'(1));
`else
    chk("no wdog sep", VW'(sawsep), VW'(0));
    chk("no wdog burn cycles", VW'(nb), VW'(40));
    chk("no wdog trip", VW'(o_wd[2]), VW'(0));
`endif
    step(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of burn stages sequenced (2..15).
REQ-002 Parameter W, default 64, width of every per-stage parameter field.
REQ-003 Parameter COAST_CYCLES, default 2, idle cycles between separation and next stage load (0 allowed).
REQ-004 Parameter TICKS_PER_S, default 1000, clock cycles per burntime unit (watchdog only).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 resetb  in  1  asynchronous, active-low reset.
REQ-007 launch  in  1  one-cycle start request.
REQ-008 ignition_end  in  1  burn-complete pulse from velocity engine.
REQ-009 abort  in  1  level abort request.
REQ-010 isp_tbl, mass0_tbl, prop_tbl, burn_tbl  in  NUM_STAGES*W each  stage k at [k*W +: W].
REQ-011 stage_idx  out  4  current stage, 0-based.
REQ-012 isp, initial_weight, propellant_weight, burntime  out  W each  latched parameters of stage_idx.
REQ-013 engine_resetb  out  1  active-low reset to velocity engine.
REQ-014 burning, sep_pulse, mission_done, aborted, wdog_trip  out  1 each  status.

Function
REQ-015 States IDLE, LOAD, ARM, BURN, SEP, COAST, DONE, ABORT; one-hot or binary, encoding from the package.
REQ-016 IDLE: launch=1 -> LOAD, stage_idx=0; other inputs ignored.
REQ-017 LOAD: parameter outputs register table entry stage_idx in 1 cycle -> ARM.
REQ-018 ARM: engine_resetb=0 for exactly 1 cycle -> BURN; engine_resetb=1 in IDLE, LOAD, BURN, SEP, COAST, DONE.
REQ-019 BURN: burning=1; ignition_end=1 -> SEP next cycle.
REQ-020 SEP: sep_pulse=1 for exactly 1 cycle; last stage -> DONE, else -> COAST.
REQ-021 COAST: counts COAST_CYCLES cycles, then stage_idx+1 and -> LOAD; COAST_CYCLES=0 -> LOAD directly from SEP.
REQ-022 DONE: mission_done=1, parameters hold; exit only by reset.
REQ-023 abort=1 in LOAD/ARM/BURN/SEP/COAST -> ABORT next cycle; ignored in IDLE and DONE.
REQ-024 ABORT: aborted=1, engine_resetb=0 held, burning=0; exit only by reset.
REQ-025 abort and ignition_end same cycle in BURN: abort wins, no sep_pulse.
REQ-026 launch outside IDLE and ignition_end outside BURN are ignored.
REQ-027 Stage-to-stage latency from ignition_end to next ARM = 3+COAST_CYCLES cycles.

Reset
REQ-028 resetb low: state IDLE, stage_idx=0, isp/initial_weight/propellant_weight=0, burntime=1, engine_resetb=0, all status outputs 0.
REQ-029 Reset mid-burn aborts sequence silently (aborted stays 0); first clock after release is IDLE.

Configuration
REQ-030 Macro STAGE_SEQ_WDOG_EN defined: counter clears on ARM, counts in BURN; reaching burntime*TICKS_PER_S without ignition_end forces SEP and sets sticky wdog_trip until reset.
REQ-031 Macro undefined: no counter, BURN waits indefinitely, wdog_trip tied 0.

Structure
REQ-032 Package stage_seq_pkg holds state encoding, stage_idx width, default W and TICKS_PER_S.
REQ-033 Sub-module burn_watchdog holds the REQ-030 counter, instantiated only under STAGE_SEQ_WDOG_EN.

Verification
REQ-034 Nominal 4 stages, COAST_CYCLES=2: launch, ignition_end 20 cycles after each ARM -> 4 sep_pulses, stage_idx 0..3, mission_done after 4th SEP.
REQ-035 Table isp_tbl={421,421,421,263} (stage 3..0): in LOAD of stage 1, isp=421 the following cycle; stage 0 isp=263.
REQ-036 abort asserted in BURN of stage 1 same cycle as ignition_end -> ABORT, aborted=1, engine_resetb=0, no sep_pulse.
REQ-037 resetb low during stage 2 BURN -> all outputs at REQ-028 values; new launch restarts at stage 0.
REQ-038 COAST_CYCLES=0 -> ignition_end to next engine_resetb low = 3 cycles.
REQ-039 STAGE_SEQ_WDOG_EN, burntime=2, TICKS_PER_S=5, no ignition_end -> SEP after 10 BURN cycles, wdog_trip=1.
